// File: rtl/risc_pkg.sv
// Shared RV32I control definitions: opcodes, datapath select encodings,
// multi-cycle state/trap enums and the registered decode record.
package risc_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } op_enum_alu;

  typedef enum logic [1:0] {WR_ALU, WR_MEM, WR_PC, WR_IMM} op_enum_wr_data_sel;

  // Encoded to match funct3[1:0] of loads/stores.
  typedef enum logic [1:0] {DMEM_BYTE, DMEM_HALF, DMEM_WORD} op_enum_dmem_size;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} op_enum_mc_state;

  typedef enum logic [1:0] {TRAP_NONE, TRAP_ILLEGAL, TRAP_IMEM_TO, TRAP_DMEM_TO} op_enum_trap;

  typedef struct packed {
    logic               valid;
    logic               is_load;
    logic               is_store;
    logic               is_branch;
    logic               is_jump;
    logic               op1_pc;
    logic               op2_imm;
    op_enum_alu         alu_op;
    op_enum_wr_data_sel wr_sel;
    op_enum_dmem_size   size;
    logic               zero_ex;
  } dec_t;

  // Only R-type uses funct7[5] to pick SUB; shifts use it in both R and I forms.
  function automatic op_enum_alu alu_func(input logic [2:0] f3, input logic f7b5,
                                          input logic is_r);
    case (f3)
      F3_ADD:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return f7b5 ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_multicycle_decode.sv
// Combinational instruction decode: IR -> type flags, operand/writeback
// selects, ALU function and data-memory access shape.
module control_decode
  import risc_pkg::*;
(
  input  logic [31:0] ir_i,
  output dec_t        dec_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7b5;
  logic       field_unused;

  assign opc          = ir_i[6:0];
  assign f3           = ir_i[14:12];
  assign f7b5         = ir_i[30];
  assign field_unused = ^{ir_i[31], ir_i[29:15], ir_i[11:7]};

  always_comb begin
    dec_o        = '0;
    dec_o.alu_op = ALU_ADD;
    dec_o.wr_sel = WR_ALU;
    dec_o.size   = op_enum_dmem_size'(f3[1:0]);
    case (opc)
      OPC_OP: begin
        dec_o.valid  = 1'b1;
        dec_o.alu_op = alu_func(f3, f7b5, 1'b1);
      end
      OPC_OPIMM: begin
        dec_o.valid   = 1'b1;
        dec_o.op2_imm = 1'b1;
        dec_o.alu_op  = alu_func(f3, f7b5, 1'b0);
      end
      OPC_LUI: begin
        dec_o.valid   = 1'b1;
        dec_o.op2_imm = 1'b1;
        dec_o.wr_sel  = WR_IMM;
      end
      OPC_AUIPC: begin
        dec_o.valid   = 1'b1;
        dec_o.op1_pc  = 1'b1;
        dec_o.op2_imm = 1'b1;
      end
      OPC_JAL: begin
        dec_o.valid   = 1'b1;
        dec_o.is_jump = 1'b1;
        dec_o.op1_pc  = 1'b1;
        dec_o.op2_imm = 1'b1;
        dec_o.wr_sel  = WR_PC;
      end
      OPC_JALR: begin
        dec_o.valid   = (f3 == 3'b000);
        dec_o.is_jump = 1'b1;
        dec_o.op2_imm = 1'b1;
        dec_o.wr_sel  = WR_PC;
      end
      OPC_BRANCH: begin
        dec_o.valid     = (f3[2:1] != 2'b01);
        dec_o.is_branch = 1'b1;
        dec_o.op1_pc    = 1'b1;
        dec_o.op2_imm   = 1'b1;
      end
      // Legal loads: LB/LH/LW/LBU/LHU.
      OPC_LOAD: begin
        dec_o.valid   = (f3[1:0] != 2'b11) && !(f3[2] && f3[1]);
        dec_o.is_load = 1'b1;
        dec_o.op2_imm = 1'b1;
        dec_o.wr_sel  = WR_MEM;
        dec_o.zero_ex = f3[2];
      end
      OPC_STORE: begin
        dec_o.valid    = !f3[2] && (f3[1:0] != 2'b11);
        dec_o.is_store = 1'b1;
        dec_o.op2_imm  = 1'b1;
      end
      default: dec_o.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_multicycle.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with imem/dmem
// handshakes, bounded memory waits and a sticky trap.
module control_multicycle
  import risc_pkg::*;
#(
  parameter int IMEM_TIMEOUT = 16,
  parameter int DMEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  input  logic               branch_taken,
  output logic               imem_req,
  output logic               ir_wr,
  output logic               mdr_wr,
  output logic               pc_wr,
  output logic               pc_sel,
  output logic               op1_sel,
  output logic               op2_sel,
  output op_enum_alu         alu_op,
  output op_enum_wr_data_sel rf_wr_data_sel,
  output logic               rf_wr_en,
  output logic               dmem_req,
  output logic               dmem_wr,
  output op_enum_dmem_size   dmem_size,
  output logic               dmem_zero_ex,
  output logic               trap,
  output op_enum_trap        trap_cause
);

  localparam int MAX_TO = (IMEM_TIMEOUT > DMEM_TIMEOUT) ? IMEM_TIMEOUT : DMEM_TIMEOUT;
  localparam int CNT_W  = (MAX_TO < 1) ? 1 : $clog2(MAX_TO + 1);
  localparam logic [CNT_W-1:0] IMEM_LIM = CNT_W'((IMEM_TIMEOUT > 0) ? IMEM_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] DMEM_LIM = CNT_W'((DMEM_TIMEOUT > 0) ? DMEM_TIMEOUT - 1 : 0);

  op_enum_mc_state state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  dec_t            dec_q, dec_d, dec_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            trap_q, trap_d;
  op_enum_trap     cause_q, cause_d;
  logic            valid_unused;

  control_decode u_decode (
    .ir_i  (ir_q),
    .dec_o (dec_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ir_q    <= '0;
      dec_q   <= '0;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  // Counter defaults to clear; it only advances while a memory wait continues.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    dec_d    = dec_q;
    cnt_d    = '0;
    trap_d   = trap_q;
    cause_d  = cause_q;
    imem_req = 1'b0;
    ir_wr    = 1'b0;
    mdr_wr   = 1'b0;
    pc_wr    = 1'b0;
    pc_sel   = 1'b0;
    op1_sel  = 1'b0;
    op2_sel  = 1'b0;
    alu_op   = ALU_ADD;
    rf_wr_en = 1'b0;
    dmem_req = 1'b0;
    dmem_wr  = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_wr   = 1'b1;
          ir_d    = instr;
          state_d = DECODE;
        end else if ((IMEM_TIMEOUT != 0) && (cnt_q == IMEM_LIM)) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = TRAP_IMEM_TO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DECODE: begin
        dec_d = dec_w;
        if (!dec_w.valid) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = TRAP_ILLEGAL;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        op1_sel = dec_q.op1_pc;
        op2_sel = dec_q.op2_imm;
        alu_op  = dec_q.alu_op;
        if (dec_q.is_branch) begin
          pc_wr   = 1'b1;
          pc_sel  = branch_taken;
          state_d = FETCH;
        end else if (dec_q.is_load || dec_q.is_store) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_wr  = dec_q.is_store;
        if (dmem_ack) begin
          if (dec_q.is_store) begin
            pc_wr   = 1'b1;
            state_d = FETCH;
          end else begin
            mdr_wr  = 1'b1;
            state_d = WB;
          end
        end else if ((DMEM_TIMEOUT != 0) && (cnt_q == DMEM_LIM)) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = TRAP_DMEM_TO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB: begin
        rf_wr_en = 1'b1;
        pc_wr    = 1'b1;
        pc_sel   = dec_q.is_jump;
        state_d  = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
    // Requests and strobes drop in the same cycle reset is asserted.
    if (reset) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_wr  = 1'b0;
      ir_wr    = 1'b0;
      mdr_wr   = 1'b0;
      pc_wr    = 1'b0;
      rf_wr_en = 1'b0;
    end
  end

  assign rf_wr_data_sel = dec_q.wr_sel;
  assign dmem_size      = dec_q.size;
  assign dmem_zero_ex   = dec_q.zero_ex;
  assign trap           = trap_q;
  assign trap_cause     = cause_q;
  assign valid_unused   = dec_q.valid;

endmodule

// File: tb/tb_control_multicycle.sv
// Self-checking bench for control_multicycle: per-cycle strobe/select
// expectations are queued with the stimulus and popped as the DUT runs.
module tb_control_multicycle;
  import risc_pkg::*;

  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] instr = '0;
  logic imem_ack = 1'b0, dmem_ack = 1'b0, branch_taken = 1'b0;
  logic imem_req, ir_wr, mdr_wr, pc_wr, pc_sel, op1_sel, op2_sel, rf_wr_en;
  logic dmem_req, dmem_wr, dmem_zero_ex, trap;
  op_enum_alu         alu_op;
  op_enum_wr_data_sel rf_wr_data_sel;
  op_enum_dmem_size   dmem_size;
  op_enum_trap        trap_cause;

  control_multicycle #(.IMEM_TIMEOUT(16), .DMEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .branch_taken(branch_taken), .imem_req(imem_req), .ir_wr(ir_wr), .mdr_wr(mdr_wr),
    .pc_wr(pc_wr), .pc_sel(pc_sel), .op1_sel(op1_sel), .op2_sel(op2_sel), .alu_op(alu_op),
    .rf_wr_data_sel(rf_wr_data_sel), .rf_wr_en(rf_wr_en), .dmem_req(dmem_req),
    .dmem_wr(dmem_wr), .dmem_size(dmem_size), .dmem_zero_ex(dmem_zero_ex), .trap(trap),
    .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  // {imem_req, ir_wr, dmem_req, dmem_wr, mdr_wr, pc_wr, pc_sel, rf_wr_en, trap}
  logic [8:0]  obs;
  logic [10:0] aux;
  assign obs = {imem_req, ir_wr, dmem_req, dmem_wr, mdr_wr, pc_wr, pc_sel, rf_wr_en, trap};
  assign aux = {alu_op, op1_sel, op2_sel, rf_wr_data_sel, dmem_size, dmem_zero_ex};

  localparam logic [8:0] S_NONE  = 9'b000000000;
  localparam logic [8:0] S_FETCH = 9'b110000000;
  localparam logic [8:0] S_FWAIT = 9'b100000000;
  localparam logic [8:0] S_WB    = 9'b000001010;
  localparam logic [8:0] S_WBJ   = 9'b000001110;
  localparam logic [8:0] S_MEMW  = 9'b001000000;
  localparam logic [8:0] S_MEMLD = 9'b001010000;
  localparam logic [8:0] S_MEMST = 9'b001101000;
  localparam logic [8:0] S_BRT   = 9'b000001100;
  localparam logic [8:0] S_BRN   = 9'b000001000;
  localparam logic [8:0] S_TRAP  = 9'b000000001;

  localparam logic [10:0] M_ALU = 11'h780, M_OP1 = 11'h040, M_OP2 = 11'h020;
  localparam logic [10:0] M_WR  = 11'h018, M_SZ  = 11'h006, M_ZX  = 11'h001;
  localparam logic [2:0]  A_I = 3'b100, A_D = 3'b010, BR = 3'b001, NO = 3'b000;

  int total = 0;
  int bad   = 0;
  logic [2:0]  stim_q [$];
  logic [8:0]  exp_q  [$];
  logic [10:0] msk_q  [$];
  logic [10:0] aux_q  [$];

  function automatic logic [10:0] ax(input op_enum_alu a, input logic o1, input logic o2,
                                     input op_enum_wr_data_sel w, input op_enum_dmem_size s,
                                     input logic z);
    return {a, o1, o2, w, s, z};
  endfunction

  task automatic push(input logic [2:0] s, input logic [8:0] e, input logic [10:0] m,
                      input logic [10:0] a);
    stim_q.push_back(s);
    exp_q.push_back(e);
    msk_q.push_back(m);
    aux_q.push_back(a);
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (obs !== S_NONE) begin bad++; $display("FAIL reset_outs got=%b want=%b", obs, S_NONE); end
    total++;
    if (trap_cause !== TRAP_NONE) begin bad++; $display("FAIL reset_cause got=%0d want=%0d", trap_cause, TRAP_NONE); end
    reset = 1'b0;
    #1;
    total++;
    if (obs !== S_FWAIT) begin bad++; $display("FAIL reset_release got=%b want=%b", obs, S_FWAIT); end
    @(negedge clk);
  endtask

  // Back-to-back ALU/U/J instructions with both acks held high throughout.
  task automatic test_alu_table();
    logic [31:0] tin [7];
    logic [10:0] tex [7];
    logic [10:0] tmk [7];
    logic [8:0]  twb [7];
    op_enum_wr_data_sel tws [7];
    logic [8:0] e;
    logic [10:0] m, a;
    tin = '{32'h002081B3, 32'h402081B3, 32'h0030D193, 32'h4030D193,
            32'h123451B7, 32'h008001EF, 32'h00000197};
    tex[0] = ax(ALU_ADD, 1'b0, 1'b0, WR_ALU, DMEM_BYTE, 1'b0); tmk[0] = M_ALU | M_OP1 | M_OP2;
    tex[1] = ax(ALU_SUB, 1'b0, 1'b0, WR_ALU, DMEM_BYTE, 1'b0); tmk[1] = M_ALU | M_OP1 | M_OP2;
    tex[2] = ax(ALU_SRL, 1'b0, 1'b1, WR_ALU, DMEM_BYTE, 1'b0); tmk[2] = M_ALU | M_OP1 | M_OP2;
    tex[3] = ax(ALU_SRA, 1'b0, 1'b1, WR_ALU, DMEM_BYTE, 1'b0); tmk[3] = M_ALU | M_OP1 | M_OP2;
    tex[4] = ax(ALU_ADD, 1'b0, 1'b0, WR_ALU, DMEM_BYTE, 1'b0); tmk[4] = '0;
    tex[5] = ax(ALU_ADD, 1'b1, 1'b0, WR_ALU, DMEM_BYTE, 1'b0); tmk[5] = M_OP1;
    tex[6] = ax(ALU_ADD, 1'b1, 1'b0, WR_ALU, DMEM_BYTE, 1'b0); tmk[6] = M_OP1;
    twb = '{S_WB, S_WB, S_WB, S_WB, S_WB, S_WBJ, S_WB};
    tws = '{WR_ALU, WR_ALU, WR_ALU, WR_ALU, WR_IMM, WR_PC, WR_ALU};
    for (int k = 0; k < 7; k++) begin
      instr = tin[k];
      push(3'b110, S_FETCH, '0, '0);
      push(3'b110, S_NONE, '0, '0);
      push(3'b110, S_NONE, tmk[k], tex[k]);
      push(3'b110, twb[k], M_WR, ax(ALU_ADD, 1'b0, 1'b0, tws[k], DMEM_BYTE, 1'b0));
      for (int cyc = 0; exp_q.size() > 0; cyc++) begin
        {imem_ack, dmem_ack, branch_taken} = stim_q.pop_front();
        #1;
        e = exp_q.pop_front(); m = msk_q.pop_front(); a = aux_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL alu%0d cyc%0d strobes got=%b want=%b", k, cyc, obs, e); end
        if (m != '0) begin
          total++;
          if ((aux & m) !== (a & m)) begin bad++; $display("FAIL alu%0d cyc%0d selects got=%h want=%h", k, cyc, aux & m, a & m); end
        end
        @(negedge clk);
      end
    end
  endtask

  // LW with the dmem ack on MEM cycle ackcyc (1-based); 4 is the timeout-limit cycle.
  task automatic test_load(input int ackcyc);
    logic [8:0] e;
    logic [10:0] m, a;
    instr = 32'h0000A183;
    push(A_I, S_FETCH, '0, '0);
    push(NO, S_NONE, '0, '0);
    push(NO, S_NONE, M_ALU | M_OP1 | M_OP2, ax(ALU_ADD, 1'b0, 1'b1, WR_ALU, DMEM_BYTE, 1'b0));
    for (int i = 1; i < ackcyc; i++)
      push(NO, S_MEMW, M_SZ | M_ZX, ax(ALU_ADD, 1'b0, 1'b0, WR_ALU, DMEM_WORD, 1'b0));
    push(A_D, S_MEMLD, M_SZ | M_ZX, ax(ALU_ADD, 1'b0, 1'b0, WR_ALU, DMEM_WORD, 1'b0));
    push(NO, S_WB, M_WR, ax(ALU_ADD, 1'b0, 1'b0, WR_MEM, DMEM_BYTE, 1'b0));
    for (int cyc = 0; exp_q.size() > 0; cyc++) begin
      {imem_ack, dmem_ack, branch_taken} = stim_q.pop_front();
      #1;
      e = exp_q.pop_front(); m = msk_q.pop_front(); a = aux_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL load_ack%0d cyc%0d strobes got=%b want=%b", ackcyc, cyc, obs, e); end
      if (m != '0) begin
        total++;
        if ((aux & m) !== (a & m)) begin bad++; $display("FAIL load_ack%0d cyc%0d selects got=%h want=%h", ackcyc, cyc, aux & m, a & m); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [8:0] e;
    logic [10:0] m, a;
    instr = 32'h00208463;
    for (int t = 1; t >= 0; t--) begin
      push(A_I, S_FETCH, '0, '0);
      push(NO, S_NONE, '0, '0);
      push(t[0] ? BR : NO, t[0] ? S_BRT : S_BRN, M_ALU | M_OP1,
           ax(ALU_ADD, 1'b1, 1'b0, WR_ALU, DMEM_BYTE, 1'b0));
      for (int cyc = 0; exp_q.size() > 0; cyc++) begin
        {imem_ack, dmem_ack, branch_taken} = stim_q.pop_front();
        #1;
        e = exp_q.pop_front(); m = msk_q.pop_front(); a = aux_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL branch_t%0d cyc%0d strobes got=%b want=%b", t, cyc, obs, e); end
        if (m != '0) begin
          total++;
          if ((aux & m) !== (a & m)) begin bad++; $display("FAIL branch_t%0d cyc%0d selects got=%h want=%h", t, cyc, aux & m, a & m); end
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_store_lbu();
    logic [8:0] e;
    logic [10:0] m, a;
    instr = 32'h00208023;
    push(A_I, S_FETCH, '0, '0);
    push(NO, S_NONE, '0, '0);
    push(NO, S_NONE, M_ALU | M_OP2, ax(ALU_ADD, 1'b0, 1'b1, WR_ALU, DMEM_BYTE, 1'b0));
    push(A_D, S_MEMST, M_SZ, ax(ALU_ADD, 1'b0, 1'b0, WR_ALU, DMEM_BYTE, 1'b0));
    for (int cyc = 0; exp_q.size() > 0; cyc++) begin
      {imem_ack, dmem_ack, branch_taken} = stim_q.pop_front();
      #1;
      e = exp_q.pop_front(); m = msk_q.pop_front(); a = aux_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL sb cyc%0d strobes got=%b want=%b", cyc, obs, e); end
      if (m != '0) begin
        total++;
        if ((aux & m) !== (a & m)) begin bad++; $display("FAIL sb cyc%0d selects got=%h want=%h", cyc, aux & m, a & m); end
      end
      @(negedge clk);
    end
    instr = 32'h0000C183;
    push(A_I, S_FETCH, '0, '0);
    push(NO, S_NONE, '0, '0);
    push(NO, S_NONE, '0, '0);
    push(A_D, S_MEMLD, M_SZ | M_ZX, ax(ALU_ADD, 1'b0, 1'b0, WR_ALU, DMEM_BYTE, 1'b1));
    push(NO, S_WB, M_WR, ax(ALU_ADD, 1'b0, 1'b0, WR_MEM, DMEM_BYTE, 1'b0));
    for (int cyc = 0; exp_q.size() > 0; cyc++) begin
      {imem_ack, dmem_ack, branch_taken} = stim_q.pop_front();
      #1;
      e = exp_q.pop_front(); m = msk_q.pop_front(); a = aux_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL lbu cyc%0d strobes got=%b want=%b", cyc, obs, e); end
      if (m != '0) begin
        total++;
        if ((aux & m) !== (a & m)) begin bad++; $display("FAIL lbu cyc%0d selects got=%h want=%h", cyc, aux & m, a & m); end
      end
      @(negedge clk);
    end
  endtask

  // kind 0: dmem never acks; 1: illegal instruction; 2: imem never acks.
  task automatic test_trap(input int kind);
    logic [8:0] e;
    logic [10:0] m, a;
    op_enum_trap want;
    if (kind == 2) begin
      for (int i = 0; i < 16; i++) push(NO, S_FWAIT, '0, '0);
      want = TRAP_IMEM_TO;
    end else begin
      instr = (kind == 1) ? 32'hFFFFFFFF : 32'h0000A183;
      push(A_I, S_FETCH, '0, '0);
      push(NO, S_NONE, '0, '0);
      if (kind == 0) begin
        push(NO, S_NONE, '0, '0);
        for (int i = 0; i < 4; i++) push(NO, S_MEMW, '0, '0);
        want = TRAP_DMEM_TO;
      end else begin
        want = TRAP_ILLEGAL;
      end
    end
    push(NO, S_TRAP, '0, '0);
    push(3'b110, S_TRAP, '0, '0);
    for (int cyc = 0; exp_q.size() > 0; cyc++) begin
      {imem_ack, dmem_ack, branch_taken} = stim_q.pop_front();
      #1;
      e = exp_q.pop_front(); m = msk_q.pop_front(); a = aux_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL trap%0d cyc%0d strobes got=%b want=%b", kind, cyc, obs, e); end
      if (m != '0) begin
        total++;
        if ((aux & m) !== (a & m)) begin bad++; $display("FAIL trap%0d cyc%0d selects got=%h want=%h", kind, cyc, aux & m, a & m); end
      end
      @(negedge clk);
    end
    total++;
    if (trap_cause !== want) begin bad++; $display("FAIL trap%0d cause got=%0d want=%0d", kind, trap_cause, want); end
    {imem_ack, dmem_ack, branch_taken} = NO;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (obs !== S_FWAIT) begin bad++; $display("FAIL trap%0d after_reset got=%b want=%b", kind, obs, S_FWAIT); end
    total++;
    if (trap_cause !== TRAP_NONE) begin bad++; $display("FAIL trap%0d cause_cleared got=%0d want=%0d", kind, trap_cause, TRAP_NONE); end
  endtask

  task automatic test_mid_reset();
    logic [8:0] e;
    logic [10:0] m, a;
    instr = 32'h0000A183;
    push(A_I, S_FETCH, '0, '0);
    push(NO, S_NONE, '0, '0);
    push(NO, S_NONE, '0, '0);
    push(NO, S_MEMW, '0, '0);
    push(NO, S_MEMW, '0, '0);
    for (int cyc = 0; exp_q.size() > 0; cyc++) begin
      {imem_ack, dmem_ack, branch_taken} = stim_q.pop_front();
      #1;
      e = exp_q.pop_front(); m = msk_q.pop_front(); a = aux_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL midrst cyc%0d strobes got=%b want=%b", cyc, obs, e); end
      if (m != '0) begin
        total++;
        if ((aux & m) !== (a & m)) begin bad++; $display("FAIL midrst cyc%0d selects got=%h want=%h", cyc, aux & m, a & m); end
      end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    total++;
    if (obs !== S_NONE) begin bad++; $display("FAIL midrst req_drop got=%b want=%b", obs, S_NONE); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (obs !== S_FWAIT) begin bad++; $display("FAIL midrst release got=%b want=%b", obs, S_FWAIT); end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_alu_table();
    test_load(3);
    test_load(4);
    test_branch();
    test_store_lbu();
    test_trap(0);
    test_trap(1);
    test_trap(2);
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
